// File: rtl/down_width_conv_pkt_if.sv
// Byte-strobed packet stream bundle: data, strobes, last, valid/ready handshake.
interface down_width_conv_pkt_if #(
    parameter int WIDTH = 64
);
    logic [WIDTH-1:0]   data;
    logic [WIDTH/8-1:0] strb;
    logic               last;
    logic               valid;
    logic               ready;

    modport master (output data, strb, last, valid, input ready);
    modport slave  (input data, strb, last, valid, output ready);
endinterface

// File: rtl/down_width_conv_pkt.sv
// Down width converter: splits each wide word into narrow sub-words in emission order,
// optionally dropping all-null sub-words, with last marking the final emitted beat.
module down_width_conv_pkt #(
    parameter int DIN_WIDTH  = 64,
    parameter int DOUT_WIDTH = 16,
    parameter int ORDER      = 0,
    parameter int SKIP_NULL  = 1
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  cen,
    down_width_conv_pkt_if.slave  din,
    down_width_conv_pkt_if.master dout
);
    localparam int RATIO = DIN_WIDTH / DOUT_WIDTH;
    localparam int SB    = DOUT_WIDTH / 8;
    localparam int IDX_W = (RATIO > 1) ? $clog2(RATIO) : 1;
    localparam logic [RATIO-1:0] NULL_MASK = {1'b1, {(RATIO-1){1'b0}}};

    generate
        if ((DOUT_WIDTH <= 0) || (DIN_WIDTH % 8 != 0) || (DOUT_WIDTH % 8 != 0) ||
            (DIN_WIDTH % DOUT_WIDTH != 0) || (DIN_WIDTH <= DOUT_WIDTH) ||
            (ORDER != 0 && ORDER != 1) || (SKIP_NULL != 0 && SKIP_NULL != 1)) begin : g_bad_params
            $error("down_width_conv_pkt: illegal parameter combination");
        end
    endgenerate

    logic [RATIO-1:0][DOUT_WIDTH-1:0] slot_data;
    logic [RATIO-1:0][DOUT_WIDTH-1:0] hold_data;
    logic [RATIO-1:0][SB-1:0]         slot_strb;
    logic [RATIO-1:0][SB-1:0]         hold_strb;
    logic [RATIO-1:0]                 load_mask;
    logic [RATIO-1:0]                 pend;
    logic                             hold_last;
    logic [IDX_W-1:0]                 idx;
    logic                             one_left;
    logic                             in_fire;
    logic                             out_fire;
    logic                             do_load;

    // Slots are stored in emission order so slot 0 always leaves first.
    generate
        for (genvar k = 0; k < RATIO; k++) begin : g_slot
            localparam int SRC = (ORDER != 0) ? (RATIO - 1 - k) : k;
            assign slot_data[k] = din.data[SRC*DOUT_WIDTH +: DOUT_WIDTH];
            assign slot_strb[k] = din.strb[SRC*SB +: SB];
            assign load_mask[k] = (SKIP_NULL != 0) ? (|slot_strb[k]) : 1'b1;
        end
    endgenerate

    always_comb begin
        idx = '0;
        for (int k = RATIO - 1; k >= 0; k--) begin
            if (pend[k]) idx = IDX_W'(k);
        end
    end

    assign one_left = (pend != '0) && ((pend & (pend - 1'b1)) == '0);

    assign din.ready  = cen & rstn & ((pend == '0) | (dout.ready & one_left));
    assign dout.valid = cen & (pend != '0);
    assign dout.data  = hold_data[idx];
    assign dout.strb  = hold_strb[idx];
    assign dout.last  = hold_last & one_left;

    assign in_fire  = din.valid & din.ready;
    assign out_fire = dout.valid & dout.ready;
    // A null non-last word is swallowed, so the final-beat clear must still happen.
    assign do_load  = in_fire & ((load_mask != '0) | din.last);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            hold_data <= '0;
            hold_strb <= '0;
            hold_last <= 1'b0;
            pend      <= '0;
        end else if (cen) begin
            if (do_load) begin
                hold_data <= slot_data;
                hold_strb <= slot_strb;
                hold_last <= din.last;
                pend      <= (load_mask != '0) ? load_mask : NULL_MASK;
            end else if (out_fire) begin
                pend[idx] <= 1'b0;
            end
        end
    end
endmodule
